// File: rtl/alu_result_stage_pkg.sv
// Shared ALU select codes, flag positions and select decode helpers.
package alu_result_stage_pkg;

  localparam logic [3:0] SEL_PASS = 4'b0000;
  localparam logic [3:0] SEL_INC  = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_ADC  = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0100;
  localparam logic [3:0] SEL_SBB  = 4'b0101;
  localparam logic [3:0] SEL_DEC  = 4'b0110;
  localparam logic [3:0] SEL_AND  = 4'b0111;
  localparam logic [3:0] SEL_OR   = 4'b1000;
  localparam logic [3:0] SEL_XOR  = 4'b1001;
  localparam logic [3:0] SEL_SHL  = 4'b1010;
  localparam logic [3:0] SEL_NOT  = 4'b1011;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  function automatic logic is_arith(input logic [3:0] sel);
    return (sel >= SEL_INC) && (sel <= SEL_DEC);
  endfunction

  function automatic logic is_add(input logic [3:0] sel);
    return (sel == SEL_ADD) || (sel == SEL_ADC);
  endfunction

  function automatic logic is_sub(input logic [3:0] sel);
    return (sel == SEL_SUB) || (sel == SEL_SBB);
  endfunction

  function automatic logic is_illegal(input logic [3:0] sel);
    return sel[3] & sel[2];
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready bundle between the ALU, the result stage and its consumer.
interface alu_result_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_result;
  logic [3:0]  in_select;
  logic        in_a_msb;
  logic        in_b_msb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_flags;

  modport slave (
    input  in_valid, in_result, in_select,
    input  in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

  modport master (
    output in_valid, in_result, in_select,
    output in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational Z/N/C/V derivation from an ALU result and its select code.
module alu_flag_gen
  import alu_result_stage_pkg::*;
(
  input  logic [16:0] result,
  input  logic [3:0]  select,
  input  logic        a_msb,
  input  logic        b_msb,
  output logic [3:0]  flags
);

  logic r15;
  logic v;

  assign r15 = result[15];

  always_comb begin
    v = 1'b0;
    unique case (1'b1)
      (select == SEL_INC): v = ~a_msb & r15;
      is_add(select):      v = (a_msb == b_msb) & (r15 != a_msb);
      is_sub(select):      v = (a_msb != b_msb) & (r15 != a_msb);
      (select == SEL_DEC): v = a_msb & ~r15;
      default:             v = 1'b0;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (result[15:0] == 16'h0000);
    flags[FLG_N] = r15;
    flags[FLG_C] = is_arith(select) & result[16];
    flags[FLG_V] = v;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result FIFO behind the ALU with flag capture, accumulator feedback,
// committed-op counter and sticky illegal-select error.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_stage_if.slave bus,
  output logic [15:0]      acc,
  output logic [CNT_W-1:0] op_count,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [15:0]   mem_data  [DEPTH];
  logic [3:0]    mem_flags [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    last_flags;
  logic [3:0]    flags;
  logic          push;
  logic          pop;
  logic          wr;

  alu_flag_gen u_flag_gen (
    .result (bus.in_result),
    .select (bus.in_select),
    .a_msb  (bus.in_a_msb),
    .b_msb  (bus.in_b_msb),
    .flags  (flags)
  );

  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  assign wr   = push & ~is_illegal(bus.in_select);

  // When empty the head shows the last popped entry, which acc already holds.
  assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr]  : acc;
  assign bus.out_flags = bus.out_valid ? mem_flags[rd_ptr] : last_flags;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wr_ptr]  <= bus.in_result[15:0];
      mem_flags[wr_ptr] <= flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      acc        <= '0;
      last_flags <= '0;
      op_count   <= '0;
      err        <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        acc        <= bus.out_data;
        last_flags <= bus.out_flags;
        op_count   <= op_count + CNT_W'(1);
      end
      if (wr && !pop)
        count <= count + (AW+1)'(1);
      else if (!wr && pop)
        count <= count - (AW+1)'(1);
      if (push && !wr)
        err <= 1'b1;
    end
  end

endmodule
